// File: rtl/vcd_change_recorder.sv
// vcd_change_recorder: logs {ts, channel, value} on masked channel changes into a valid/ready FIFO.
// Build option REC_DUMPALL_EN: enable rise snapshots every masked channel as ts=0 entries.

module vcd_ch_slot #(
  parameter int CH_W = 8,
  parameter int TS_W = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic            snap_i,
  input  logic            detect_i,
  input  logic            clr_i,
  input  logic            mask_i,
  input  logic            grant_i,
  input  logic [CH_W-1:0] data_i,
  input  logic [TS_W-1:0] ts_i,
  output logic            pend_o,
  output logic [CH_W-1:0] pend_val_o,
  output logic [TS_W-1:0] pend_ts_o,
  output logic            lost_o
);
  logic [CH_W-1:0] last_q;
  logic            pend_q;
  logic [CH_W-1:0] pend_val_q;
  logic [TS_W-1:0] pend_ts_q;
  logic            chg;

  // last_q tracks every channel so unmasking never yields a stale change
  assign chg    = detect_i && mask_i && (data_i != last_q);
  assign lost_o = chg && pend_q && !grant_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q     <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      pend_ts_q  <= '0;
    end else begin
      if (load_i || detect_i) last_q <= data_i;
      if (load_i && snap_i && mask_i) begin
        pend_q     <= 1'b1;
        pend_val_q <= data_i;
        pend_ts_q  <= '0;
      end else if (clr_i || !mask_i) begin
        pend_q <= 1'b0;
      end else if (chg) begin
        pend_q     <= 1'b1;
        pend_val_q <= data_i;
        pend_ts_q  <= ts_i;
      end else if (grant_i) begin
        pend_q <= 1'b0;
      end
    end
  end

  assign pend_o     = pend_q;
  assign pend_val_o = pend_val_q;
  assign pend_ts_o  = pend_ts_q;
endmodule

module vcd_change_recorder #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 8,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16,
  parameter int CI_W   = $clog2(NUM_CH),
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic [NUM_CH-1:0]      ch_mask_i,
  input  logic [NUM_CH*CH_W-1:0] ch_data_i,
  output logic                   rd_valid_o,
  input  logic                   rd_ready_i,
  output logic [TS_W-1:0]        rd_ts_o,
  output logic [CI_W-1:0]        rd_ch_o,
  output logic [CH_W-1:0]        rd_val_o,
  output logic [CNT_W-1:0]       count_o,
  output logic                   overflow_o,
  input  logic                   clr_ovf_i
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, DUMP, RUN} state_e;
  typedef struct packed {
    logic [TS_W-1:0] ts;
    logic [CI_W-1:0] ch;
    logic [CH_W-1:0] val;
  } entry_t;

`ifdef REC_DUMPALL_EN
  localparam logic SNAP = 1'b1;
`else
  localparam logic SNAP = 1'b0;
`endif

  state_e                      state_q;
  logic [TS_W-1:0]             ts_q;
  logic [AW-1:0]               wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]            count_q, count_d;
  logic                        ovf_q;
  entry_t                      mem_q [DEPTH];

  logic                        load, active, detect;
  logic [NUM_CH-1:0]           pend, req, grant, lost;
  logic [NUM_CH-1:0][CH_W-1:0] pend_val;
  logic [NUM_CH-1:0][TS_W-1:0] pend_ts;
  logic [CI_W-1:0]             sel;
  logic                        full, pop, wr;
  entry_t                      head;

  assign load   = (state_q == IDLE) && enable_i;
  assign active = (state_q != IDLE) && enable_i;
  assign detect = (state_q == RUN) && enable_i;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    vcd_ch_slot #(.CH_W(CH_W), .TS_W(TS_W)) u_slot (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (load),
      .snap_i     (SNAP),
      .detect_i   (detect),
      .clr_i      (!active),
      .mask_i     (ch_mask_i[i]),
      .grant_i    (grant[i]),
      .data_i     (ch_data_i[i*CH_W +: CH_W]),
      .ts_i       (ts_q),
      .pend_o     (pend[i]),
      .pend_val_o (pend_val[i]),
      .pend_ts_o  (pend_ts[i]),
      .lost_o     (lost[i])
    );
  end

  assign req  = pend & ch_mask_i;
  assign full = (count_q == CNT_W'(DEPTH));
  assign pop  = (count_q != '0) && rd_ready_i;
  // a full FIFO still accepts a write when the head leaves in the same cycle
  assign wr   = active && (|req) && (!full || pop);

  always_comb begin
    sel   = '0;
    grant = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (req[i]) sel = CI_W'(i);
    if (wr) grant[sel] = 1'b1;
  end

  assign count_d = count_q + CNT_W'(wr) - CNT_W'(pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      ts_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE:    if (enable_i) state_q <= DUMP;
        DUMP:    state_q <= enable_i ? RUN : IDLE;
        RUN:     if (!enable_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (load)        ts_q <= '0;
      else if (active) ts_q <= ts_q + TS_W'(1);
      if (wr)  wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      if (|lost)          ovf_q <= 1'b1;
      else if (clr_ovf_i) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr) mem_q[wr_ptr_q] <= '{ts: pend_ts[sel], ch: sel, val: pend_val[sel]};
  end

  assign head       = mem_q[rd_ptr_q];
  assign rd_valid_o = (count_q != '0);
  assign rd_ts_o    = rd_valid_o ? head.ts  : '0;
  assign rd_ch_o    = rd_valid_o ? head.ch  : '0;
  assign rd_val_o   = rd_valid_o ? head.val : '0;
  assign count_o    = count_q;
  assign overflow_o = ovf_q;
endmodule

// File: tb/tb_vcd_change_recorder.sv
// Directed bench for vcd_change_recorder (NUM_CH=4, CH_W=8, DEPTH=16, TS_W=16).
// Inputs change #1 after a rising edge; outputs are sampled at that same point.

module tb_vcd_change_recorder;
  logic        clk = 1'b0;
  logic        rst_n, enable, rd_ready, clr_ovf;
  logic [3:0]  mask;
  logic [31:0] data;
  logic        rd_valid, overflow;
  logic [15:0] rd_ts;
  logic [1:0]  rd_ch;
  logic [7:0]  rd_val;
  logic [4:0]  count;
  int          checks = 0;
  int          failures = 0;

  vcd_change_recorder dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .enable_i   (enable),
    .ch_mask_i  (mask),
    .ch_data_i  (data),
    .rd_valid_o (rd_valid),
    .rd_ready_i (rd_ready),
    .rd_ts_o    (rd_ts),
    .rd_ch_o    (rd_ch),
    .rd_val_o   (rd_val),
    .count_o    (count),
    .overflow_o (overflow),
    .clr_ovf_i  (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; rd_ready = 1'b0; clr_ovf = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; rd_ready = 1'b0; clr_ovf = 1'b0;
    mask = 4'b0000; data = 32'h0;
    tick(); tick();
    chk("rst_valid", rd_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ts", rd_ts, 0);
    rst_n = 1'b1;
    tick();

    // single change on ch1 observed while ts=7
    mask = 4'b0010; enable = 1'b1;
    tick(); tick();
    repeat (6) tick();
    data = 32'h0000_5A00;
    tick();
    chk("single_not_early", rd_valid, 0);
    tick();
    chk("single_valid", rd_valid, 1);
    chk("single_ts", rd_ts, 7);
    chk("single_ch", rd_ch, 1);
    chk("single_val", rd_val, 8'h5A);
    chk("single_count", count, 1);
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    chk("single_popped", count, 0);
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    chk("empty_pop_noop", count, 0);

    // reset asserted mid-run with an entry queued
    data = 32'h0000_3300;
    tick(); tick();
    chk("midrun_count", count, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", rd_valid, 0);
    chk("async_rst_count", count, 0);
    chk("async_rst_ovf", overflow, 0);
    enable = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("post_rst_count", count, 0);
    chk("post_rst_valid", rd_valid, 0);

    // ch0, ch2, ch3 change together at ts=3
    data = 32'h0; mask = 4'b1101; enable = 1'b1;
    tick(); tick(); tick(); tick();
    data = 32'h0302_0001;
    tick();
    chk("simul_e0", count, 0);
    tick();
    chk("simul_e1", count, 1);
    tick();
    chk("simul_e2", count, 2);
    tick();
    chk("simul_e3", count, 3);
    chk("simul_h0_ch", rd_ch, 0);
    chk("simul_h0_ts", rd_ts, 3);
    chk("simul_h0_val", rd_val, 8'h01);
    rd_ready = 1'b1;
    tick();
    chk("simul_h1_ch", rd_ch, 2);
    chk("simul_h1_ts", rd_ts, 3);
    chk("simul_h1_val", rd_val, 8'h02);
    tick();
    chk("simul_h2_ch", rd_ch, 3);
    chk("simul_h2_ts", rd_ts, 3);
    chk("simul_h2_val", rd_val, 8'h03);
    tick();
    rd_ready = 1'b0;
    chk("simul_drained", count, 0);

    // masked-off ch1 toggles, then unmask: nothing recorded
    data = 32'h0302_4401;
    tick(); tick();
    chk("masked_toggle", count, 0);
    mask = 4'b1111;
    tick(); tick();
    chk("unmask_no_spurious", count, 0);

    // enable drop discards pending, FIFO retained
    data = 32'h0322_4401;
    tick(); tick();
    chk("pre_drop_count", count, 1);
    data = 32'h0322_2010;
    tick();
    enable = 1'b0;
    tick();
    chk("drop_count", count, 1);
    chk("drop_head_ch", rd_ch, 2);
    chk("drop_head_val", rd_val, 8'h22);
    repeat (3) tick();
    chk("idle_count", count, 1);
    chk("idle_valid", rd_valid, 1);

    // fill to DEPTH, then overflow on ch0
    do_reset();
    mask = 4'b0001; data = 32'h0; enable = 1'b1;
    tick(); tick();
    for (int k = 1; k <= 17; k++) begin
      data[7:0] = 8'(k);
      tick();
    end
    chk("full_count", count, 16);
    chk("full_no_ovf", overflow, 0);
    data[7:0] = 8'd18;
    tick();
    chk("ovf_count", count, 16);
    chk("ovf_set", overflow, 1);
    tick();
    chk("full_wait", count, 16);
    chk("full_head", rd_val, 8'd1);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("pop_write_count", count, 16);
    chk("pop_write_head", rd_val, 8'd2);
    rd_ready = 1'b1;
    for (int i = 2; i <= 16; i++) begin
      chk("drain_val", rd_val, i);
      tick();
    end
    chk("ovf_entry_val", rd_val, 8'd18);
    chk("ovf_entry_count", count, 1);
    tick();
    rd_ready = 1'b0;
    chk("drain_empty", count, 0);
    chk("ovf_sticky", overflow, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_cleared", overflow, 0);

    // enable rise with ch1=0x11, ch3=0x33 under mask 1010
    do_reset();
    mask = 4'b1010; data = 32'h3300_1100; enable = 1'b1;
    tick(); tick(); tick(); tick();
`ifdef REC_DUMPALL_EN
    chk("dump_count", count, 2);
    chk("dump_h0_ch", rd_ch, 1);
    chk("dump_h0_val", rd_val, 8'h11);
    chk("dump_h0_ts", rd_ts, 0);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("dump_h1_ch", rd_ch, 3);
    chk("dump_h1_val", rd_val, 8'h33);
    chk("dump_h1_ts", rd_ts, 0);
`else
    chk("nodump_count", count, 0);
    chk("nodump_valid", rd_valid, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
